// File: rtl/ram_pkg.sv
// Shared types and defaults for the ram / ram_ctrl pair.
package ram_pkg;

    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_ADDR_W = 4;
    localparam logic [RAM_DATA_W-1:0] RAM_INIT_VAL = 8'h00;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_RSP
    } ctrl_state_e;

endpackage

// File: rtl/ram.sv
// 16x8 single-port RAM: synchronous write, registered read data.
module ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/ram_ctrl.sv
// Valid/ready front-end for ram: timed write/read cycles, held read response,
// and a full-depth fill sweep after reset or on a soft-clear strobe.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W         = RAM_DATA_W,
    parameter int unsigned       ADDR_W         = RAM_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL       = DATA_W'(RAM_INIT_VAL),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    output logic              init_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    ctrl_state_e       state;
    logic [ADDR_W-1:0] cnt;

    assign req_ready = (state == ST_IDLE) && !clr_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) begin
                state     <= ST_CLEAR;
                init_done <= 1'b0;
            end else begin
                state     <= ST_IDLE;
                init_done <= 1'b1;
            end
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= cnt;
                    ram_din   <= INIT_VAL;
                    cnt       <= cnt + 1'b1;
                    init_done <= 1'b0;
                    if (cnt == '1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clr_start) begin
                        state     <= ST_CLEAR;
                        init_done <= 1'b0;
                    end else begin
                        init_done <= 1'b1;
                        // ram_addr/ram_din double as the request latch, so the
                        // ram sees the request in the very next cycle.
                        if (req_valid) begin
                            ram_addr <= req_addr;
                            if (req_write) begin
                                ram_we  <= 1'b1;
                                ram_din <= req_wdata;
                                state   <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: state <= ST_IDLE;
                ST_RD: state <= ST_RDW;
                ST_RDW: begin
                    rsp_rdata <= ram_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomized self-checking bench for ram_ctrl driving the ram model.
module tb_ram_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam logic [DW-1:0] INIT = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start, init_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] mdl [16];

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .init_done(init_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
        .clk(clk), .write_enable(ram_we), .address(ram_addr),
        .data_in(ram_din), .data_out(ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        n_tests++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0 || rsp_valid !== 1'b0 ||
            rsp_rdata !== '0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_reset_vals: we=%b addr=%h din=%h rv=%b rd=%h done=%b rdy=%b, want all 0",
                     tag, ram_we, ram_addr, ram_din, rsp_valid, rsp_rdata, init_done, req_ready);
        end
    endtask

    // Called just before the first sweep edge; leaves the bench on the 16th sweep cycle.
    task automatic check_sweep(input string tag);
        for (int k = 0; k < 16; k++) begin
            tick();
            n_tests++;
            if (ram_we !== 1'b1 || ram_addr !== 4'(k) || ram_din !== INIT || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_sweep[%0d]: we=%b addr=%0d din=%h done=%b, want we=1 addr=%0d din=%h done=0",
                         tag, k, ram_we, ram_addr, ram_din, init_done, k, INIT);
            end
            if (k < 15) begin
                n_tests++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_sweep_ready[%0d]: got %b want 0", tag, k, req_ready);
                end
            end
        end
        foreach (mdl[i]) mdl[i] = INIT;
    endtask

    task automatic check_done(input string tag);
        tick();
        n_tests++;
        if (ram_we !== 1'b0 || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: we=%b done=%b rdy=%b, want we=0 done=1 rdy=1",
                     tag, ram_we, init_done, req_ready);
        end
    endtask

    task automatic handshake(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output bit ok);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (req_ready === 1'b1) ok = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL handshake_timeout: req_ready never high, want high within 100 cycles");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        handshake(1'b1, a, d, ok);
        if (ok) begin
            n_tests++;
            if (ram_we !== 1'b1 || ram_addr !== a || ram_din !== d || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_cycle: we=%b addr=%h din=%h rdy=%b, want we=1 addr=%h din=%h rdy=0",
                         ram_we, ram_addr, ram_din, req_ready, a, d);
            end
            mdl[a] = d;
            tick();
            n_tests++;
            if (ram_we !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL write_after: we=%b rdy=%b, want we=0 rdy=1", ram_we, req_ready);
            end
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int unsigned hold);
        bit ok;
        int lat;
        logic [DW-1:0] exp;
        exp = mdl[a];
        rsp_ready = (hold == 0);
        handshake(1'b0, a, '0, ok);
        if (ok) begin
            n_tests++;
            if (ram_we !== 1'b0 || ram_addr !== a) begin
                n_fail++;
                $display("FAIL read_addr: we=%b addr=%h, want we=0 addr=%h", ram_we, ram_addr, a);
            end
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            n_tests++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL read_latency: got %0d cycles want 3", lat);
            end
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
                n_fail++;
                $display("FAIL read_data[%h]: rv=%b rd=%h, want rv=1 rd=%h", a, rsp_valid, rsp_rdata, exp);
            end
            for (int unsigned h = 0; h < hold; h++) begin
                tick();
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_hold[%0d]: rv=%b rd=%h rdy=%b, want rv=1 rd=%h rdy=0",
                             h, rsp_valid, rsp_rdata, req_ready, exp);
                end
            end
            rsp_ready = 1'b1;
            tick();
            n_tests++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== exp || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL read_complete: rv=%b rd=%h rdy=%b, want rv=0 rd=%h rdy=1",
                         rsp_valid, rsp_rdata, req_ready, exp);
            end
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        check_reset_vals("por");
        rst_n = 1'b1;
        check_sweep("por");
        check_done("por");
        for (int i = 0; i < 16; i++) do_read(4'(i), 0);
    endtask

    task automatic test_write_read();
        do_write(4'd15, 8'h56);
        do_write(4'd6, 8'h36);
        do_read(4'd15, 0);
        do_read(4'd6, 0);
    endtask

    task automatic test_rsp_stall();
        do_write(4'd9, 8'($urandom));
        do_read(4'd9, 5);
    endtask

    task automatic test_clear_collision();
        do_write(4'd15, 8'h5A);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd15; clr_start = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_priority_ready: got %b want 0", req_ready);
        end
        tick();
        clr_start = 1'b0;
        n_tests++;
        if (init_done !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_enter: done=%b we=%b, want done=0 we=0", init_done, ram_we);
        end
        check_sweep("clr");
        do_read(4'd15, 0);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (!(ram_we === 1'b1 && ram_addr === 4'd7) && n < 30) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= 30) begin
            n_fail++;
            $display("FAIL midsweep_reach: sweep never reached addr 7 within 30 cycles");
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_async");
        tick();
        check_reset_vals("mid_held");
        rst_n = 1'b1;
        check_sweep("mid");
        check_done("mid");
        do_read(4'($urandom_range(0, 15)), 0);
    endtask

    task automatic test_write_then_read();
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom_range(0, 15)), 8'($urandom));
            else
                do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; clr_start = 1'b0;
        foreach (mdl[i]) mdl[i] = INIT;
        #2 rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_rsp_stall();
        test_clear_collision();
        test_reset_mid_sweep();
        test_write_then_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
